// File: rtl/matvec_scheduler.sv
// Sequences a Saber matrix-vector product b = A*s (or A^T*s) on the shared multiplier/accumulator.
// Optional MATVEC_PERF_CNT_EN adds a saturating busy-cycle counter output (cycle_count_o).
module matvec_scheduler #(
    parameter int unsigned L     = 3,
    parameter int unsigned WORDS = 64,
    parameter int unsigned AW    = 6,
    parameter int unsigned IW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             transpose_i,
    input  logic             pol_mul_done_i,
    output logic             rst_pol_mul_o,
    output logic             pol_acc_clear_o,
    output logic [IW-1:0]    a_row_o,
    output logic [IW-1:0]    a_col_o,
    output logic [IW-1:0]    s_sel_o,
    output logic             result_read_o,
    output logic [IW+AW-1:0] polmem_addr_o,
    output logic             polmem_wen_o,
    output logic             busy_o,
    output logic             done_o
`ifdef MATVEC_PERF_CNT_EN
    ,
    output logic [15:0]      cycle_count_o
`endif
);

    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MUL_RUN,
        S_MUL_GAP,
        S_WB_GAP,
        S_WB_WRITE,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   row_q, row_d;
    logic [IW-1:0]   col_q, col_d;
    logic [AW-1:0]   word_q, word_d;
    logic            tr_q, tr_d;

    logic             rst_pol_mul_d;
    logic             pol_acc_clear_d;
    logic [IW-1:0]    a_row_d;
    logic [IW-1:0]    a_col_d;
    logic [IW-1:0]    s_sel_d;
    logic             result_read_d;
    logic [IW+AW-1:0] polmem_addr_d;
    logic             polmem_wen_d;
    logic             busy_d;
    logic             done_d;

    // Next-state and counter sequencing
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        word_d  = word_q;
        tr_d    = tr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CLEAR;
                    tr_d    = transpose_i;
                    row_d   = '0;
                    col_d   = '0;
                    word_d  = '0;
                end
            end
            S_CLEAR:   state_d = S_MUL_RUN;
            S_MUL_RUN: begin
                if (pol_mul_done_i) begin
                    if (col_q == IW'(L - 1)) begin
                        state_d = S_WB_GAP;
                    end else begin
                        col_d   = col_q + IW'(1);
                        state_d = S_MUL_GAP;
                    end
                end
            end
            S_MUL_GAP: state_d = S_MUL_RUN;
            S_WB_GAP:  state_d = S_WB_WRITE;
            S_WB_WRITE: begin
                if (word_q == AW'(WORDS - 1)) begin
                    word_d = '0;
                    if (row_q == IW'(L - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + IW'(1);
                        col_d   = '0;
                        state_d = S_CLEAR;
                    end
                end else begin
                    word_d  = word_q + AW'(1);
                    state_d = S_WB_GAP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore decode of the upcoming state, registered so outputs track state_q exactly
    always_comb begin
        rst_pol_mul_d   = (state_d != S_MUL_RUN);
        pol_acc_clear_d = (state_d == S_IDLE) || (state_d == S_CLEAR) || (state_d == S_DONE);
        result_read_d   = (state_d == S_WB_WRITE);
        polmem_wen_d    = (state_d == S_WB_WRITE);
        busy_d          = (state_d != S_IDLE);
        done_d          = (state_d == S_DONE);
        a_row_d         = tr_d ? col_d : row_d;
        a_col_d         = tr_d ? row_d : col_d;
        s_sel_d         = col_d;
        polmem_addr_d   = {row_d, word_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            row_q           <= '0;
            col_q           <= '0;
            word_q          <= '0;
            tr_q            <= 1'b0;
            rst_pol_mul_o   <= 1'b1;
            pol_acc_clear_o <= 1'b1;
            result_read_o   <= 1'b0;
            polmem_wen_o    <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            a_row_o         <= '0;
            a_col_o         <= '0;
            s_sel_o         <= '0;
            polmem_addr_o   <= '0;
        end else begin
            state_q         <= state_d;
            row_q           <= row_d;
            col_q           <= col_d;
            word_q          <= word_d;
            tr_q            <= tr_d;
            rst_pol_mul_o   <= rst_pol_mul_d;
            pol_acc_clear_o <= pol_acc_clear_d;
            result_read_o   <= result_read_d;
            polmem_wen_o    <= polmem_wen_d;
            busy_o          <= busy_d;
            done_o          <= done_d;
            a_row_o         <= a_row_d;
            a_col_o         <= a_col_d;
            s_sel_o         <= s_sel_d;
            polmem_addr_o   <= polmem_addr_d;
        end
    end

`ifdef MATVEC_PERF_CNT_EN
    logic [CW-1:0] cnt_q, cnt_d;

    // Counts cycles spent working (CLEAR through WB_WRITE), saturating
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            if (start_i) begin
                cnt_d = '0;
            end
        end else if (state_q != S_DONE) begin
            if (cnt_q != {CW{1'b1}}) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_matvec_scheduler.sv
// Directed self-checking bench for matvec_scheduler with a mock multiplier (done on 10th run cycle).
module tb_matvec_scheduler;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic       transpose_i;
    logic       pol_mul_done_i;
    logic       rst_pol_mul_o;
    logic       pol_acc_clear_o;
    logic [1:0] a_row_o;
    logic [1:0] a_col_o;
    logic [1:0] s_sel_o;
    logic       result_read_o;
    logic [7:0] polmem_addr_o;
    logic       polmem_wen_o;
    logic       busy_o;
    logic       done_o;
`ifdef MATVEC_PERF_CNT_EN
    logic [15:0] cycle_count_o;
`endif

    matvec_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .transpose_i     (transpose_i),
        .pol_mul_done_i  (pol_mul_done_i),
        .rst_pol_mul_o   (rst_pol_mul_o),
        .pol_acc_clear_o (pol_acc_clear_o),
        .a_row_o         (a_row_o),
        .a_col_o         (a_col_o),
        .s_sel_o         (s_sel_o),
        .result_read_o   (result_read_o),
        .polmem_addr_o   (polmem_addr_o),
        .polmem_wen_o    (polmem_wen_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
`ifdef MATVEC_PERF_CNT_EN
        ,
        .cycle_count_o   (cycle_count_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int mcnt     = 0;
    logic force_done = 1'b0;

    // Expected a_row*100 + a_col*10 + s_sel for each of the nine passes
    int tab_n [9] = '{0, 11, 22, 100, 111, 122, 200, 211, 222};
    int tab_t [9] = '{0, 101, 202, 10, 111, 212, 20, 121, 222};

    localparam logic [19:0] RST_VEC = {6'b110000, 14'd0};

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] out_vec();
        return {rst_pol_mul_o, pol_acc_clear_o, result_read_o, polmem_wen_o, busy_o, done_o,
                a_row_o, a_col_o, s_sel_o, polmem_addr_o};
    endfunction

    // Mock multiplier: done on the 10th cycle of each run; optionally held high elsewhere
    always @(negedge clk) begin
        if (!rst_pol_mul_o) begin
            mcnt = mcnt + 1;
            pol_mul_done_i = (mcnt == 10);
        end else begin
            mcnt = 0;
            pol_mul_done_i = force_done;
        end
    end

    task automatic run_check(input logic tr, input logic disturb);
        int wr_n = 0;
        int mul_n = 0;
        int done_n = 0;
        int done_cyc = -1;
        int sel;
        logic prev_rpm;
        logic prev_wen;
        force_done = disturb;
        @(negedge clk);
        start_i = 1'b1;
        transpose_i = tr;
        @(negedge clk);
        start_i = disturb;
        transpose_i = ~tr;
        check("clear_state", {busy_o, rst_pol_mul_o, pol_acc_clear_o}, 3'b111);
`ifdef MATVEC_PERF_CNT_EN
        check("perf_clear", cycle_count_o, 0);
`endif
        prev_rpm = 1'b1;
        prev_wen = 1'b0;
        for (int cyc = 0; cyc < 520; cyc++) begin
            if (!rst_pol_mul_o && prev_rpm) begin
                if (mul_n < 9) begin
                    sel = int'(a_row_o) * 100 + int'(a_col_o) * 10 + int'(s_sel_o);
                    check("sel", sel, tr ? tab_t[mul_n] : tab_n[mul_n]);
                end
                mul_n++;
            end
            if (polmem_wen_o) begin
                check("addr", polmem_addr_o, wr_n);
                check("rd_gap", {result_read_o, prev_wen}, 2'b10);
                wr_n++;
            end
            if (done_o) begin
                done_n++;
                done_cyc = cyc;
`ifdef MATVEC_PERF_CNT_EN
                check("perf_done", cycle_count_o, 483);
`endif
            end
            prev_rpm = rst_pol_mul_o;
            prev_wen = polmem_wen_o;
            @(negedge clk);
            start_i = disturb && (done_n == 0) && (cyc % 37 == 5);
        end
        check("writes", wr_n, 192);
        check("passes", mul_n, 9);
        check("done_cnt", done_n, 1);
        check("latency", done_cyc, 483);
        check("idle_busy", busy_o, 0);
`ifdef MATVEC_PERF_CNT_EN
        check("perf_hold", cycle_count_o, 483);
`endif
        start_i = 1'b0;
        force_done = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        start_i = 1'b0;
        transpose_i = 1'b0;
        pol_mul_done_i = 1'b0;
        repeat (3) @(negedge clk);
        check("in_reset", out_vec(), RST_VEC);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_idle", out_vec(), RST_VEC);
        end

        run_check(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        run_check(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        run_check(1'b0, 1'b1);
        repeat (3) @(negedge clk);

        // Abort mid-run while address 71 is being written
        @(negedge clk);
        start_i = 1'b1;
        transpose_i = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (polmem_wen_o && polmem_addr_o == 8'd71) found = 1'b1;
        end
        check("abort_reached", found, 1);
        rst = 1'b1;
        #1;
        check("abort_outputs", out_vec(), RST_VEC);
`ifdef MATVEC_PERF_CNT_EN
        check("abort_perf", cycle_count_o, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_abort", out_vec(), RST_VEC);
        run_check(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
